// File: rtl/sw_out_port_scheduler_pkg.sv
// Shared types and helpers for the output-port switch-allocation scheduler.
// Holds the FSM encoding, default buffer depth and the width helper.
package sw_out_port_scheduler_pkg;

  localparam int DEF_BUFFER_NUM_PER_VC = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Never returns 0 so one-entry configurations still get a 1-bit field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sw_out_port_scheduler_vc_credit.sv
// Downstream credit counter for one virtual channel.
// Saturates at the buffer depth and flags an overflowing credit return.
module vc_credit_counter
  import sw_out_port_scheduler_pkg::*;
#(
  parameter int MAX   = DEF_BUFFER_NUM_PER_VC,
  parameter int CNT_W = clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             overflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;

  assign full     = (cnt_q == CNT_W'(MAX));
  assign overflow = inc & ~dec & full;
  assign nonzero  = (cnt_q != '0);
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({dec, inc})
      2'b10:   cnt_d = cnt_q - 1'b1;
      2'b01:   if (!full) cnt_d = cnt_q + 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= CNT_W'(MAX);
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sw_out_port_scheduler.sv
// Output-port scheduler: round-robin pick, wormhole lock, credit gating.
// Grants are combinational; all state moves on the next clock edge.
module sw_out_port_scheduler
  import sw_out_port_scheduler_pkg::*;
#(
  parameter int VC_NUM_PER_PORT   = 4,
  parameter int PORT_NUM          = 5,
  parameter int BUFFER_NUM_PER_VC = DEF_BUFFER_NUM_PER_VC,
  parameter int ARBITER_WIDTH     = PORT_NUM - 1,
  parameter int V_BITS            = clog2(VC_NUM_PER_PORT),
  parameter int O_BITS            = clog2(ARBITER_WIDTH),
  parameter int CNT_W             = clog2(BUFFER_NUM_PER_VC + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ARBITER_WIDTH-1:0]        req,
  input  logic [ARBITER_WIDTH*V_BITS-1:0] req_vc,
  input  logic [ARBITER_WIDTH-1:0]        req_tail,
  input  logic [VC_NUM_PER_PORT-1:0]      credit_in,
  output logic [ARBITER_WIDTH-1:0]        grant,
  output logic                            any_grant,
  output logic [V_BITS-1:0]               grant_vc,
  output logic                            locked,
  output logic [O_BITS-1:0]               owner,
  output logic [VC_NUM_PER_PORT-1:0]      credit_avail,
  output logic                            credit_err
);

  state_e              state_q, state_d;
  logic [O_BITS-1:0]   ptr_q, ptr_d;
  logic [O_BITS-1:0]   owner_q, owner_d;
  logic [V_BITS-1:0]   ovc_q, ovc_d;
  logic                cerr_q;

  logic [CNT_W-1:0]    cnt [VC_NUM_PER_PORT];
  logic [VC_NUM_PER_PORT-1:0] nz, ovf, dec;
  logic [V_BITS-1:0]   rvc [ARBITER_WIDTH];
  logic [ARBITER_WIDTH-1:0] elig, gnt;
  logic [V_BITS-1:0]   gvc;
  logic [O_BITS-1:0]   win;
  logic                found;
  int                  idx;

  function automatic logic [O_BITS-1:0] nxt(input logic [O_BITS-1:0] p);
    return (int'(p) == ARBITER_WIDTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < ARBITER_WIDTH; i++) begin
      rvc[i]  = req_vc[i*V_BITS +: V_BITS];
      elig[i] = req[i] & (cnt[rvc[i]] != '0);
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < ARBITER_WIDTH; k++) begin
      idx = (int'(ptr_q) + k) % ARBITER_WIDTH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = O_BITS'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ovc_d   = ovc_q;
    gnt     = '0;
    gvc     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt[win] = 1'b1;
          gvc      = rvc[win];
          if (req_tail[win]) begin
            ptr_d = nxt(win);
          end else begin
            state_d = ST_LOCKED;
            owner_d = win;
            ovc_d   = rvc[win];
          end
        end
      end
      ST_LOCKED: begin
        // The latched VC is used; the owner's live req_vc is ignored.
        if (req[owner_q] && nz[ovc_q]) begin
          gnt[owner_q] = 1'b1;
          gvc          = ovc_q;
          if (req_tail[owner_q]) begin
            state_d = ST_IDLE;
            ptr_d   = nxt(owner_q);
            owner_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset) begin
      gnt = '0;
      gvc = '0;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM_PER_PORT; v++)
      dec[v] = (|gnt) && (gvc == V_BITS'(v));
  end

  for (genvar v = 0; v < VC_NUM_PER_PORT; v++) begin : g_cnt
    vc_credit_counter #(
      .MAX   (BUFFER_NUM_PER_VC),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .dec      (dec[v]),
      .inc      (credit_in[v]),
      .cnt      (cnt[v]),
      .nonzero  (nz[v]),
      .overflow (ovf[v])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      ovc_q   <= '0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ovc_q   <= ovc_d;
      cerr_q  <= cerr_q | (|ovf);
    end
  end

  assign grant        = gnt;
  assign any_grant    = |gnt;
  assign grant_vc     = gvc;
  assign locked       = (state_q == ST_LOCKED);
  assign owner        = owner_q;
  assign credit_avail = nz;
  assign credit_err   = cerr_q;

endmodule

// File: tb/tb_sw_out_port_scheduler.sv
// Directed bench for sw_out_port_scheduler with hand-computed vectors.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_sw_out_port_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req_tail, credit_in;
  logic [7:0] req_vc;
  logic [3:0] grant, credit_avail;
  logic       any_grant, locked, credit_err;
  logic [1:0] grant_vc, owner;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sw_out_port_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_vc       (req_vc),
    .req_tail     (req_tail),
    .credit_in    (credit_in),
    .grant        (grant),
    .any_grant    (any_grant),
    .grant_vc     (grant_vc),
    .locked       (locked),
    .owner        (owner),
    .credit_avail (credit_avail),
    .credit_err   (credit_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    credit_in = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [3:0] e;

  initial begin
    reset = 1'b0; req = '0; req_vc = '0; req_tail = '0; credit_in = '0;
    repeat (2) @(negedge clk);
    req = 4'hF; #1;
    check("rst_grant", grant, 0);
    check("rst_anyg", any_grant, 0);
    check("rst_locked", locked, 0);
    check("rst_owner", owner, 0);
    check("rst_cav", credit_avail, 4'hF);
    check("rst_cerr", credit_err, 0);

    // round robin over single-flit packets, distinct VCs
    @(negedge clk);
    reset = 1'b1; req = 4'hF; req_tail = 4'hF; req_vc = 8'hE4;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = 4'b0001 << (i % 4);
      check("rr_grant", grant, e);
      check("rr_gvc", grant_vc, i % 4);
      check("rr_locked", locked, 0);
      @(negedge clk);
    end

    // wormhole lock: input 2, three flits to VC1
    do_reset();
    req = 4'b0010; req_tail = 4'hF; req_vc = 8'h00; #1;
    check("pre_grant", grant, 4'b0010);
    @(negedge clk);
    req = 4'b0111; req_tail = 4'b0000; req_vc = 8'h10; #1;
    check("head_grant", grant, 4'b0100);
    check("head_gvc", grant_vc, 1);
    check("head_locked", locked, 0);
    @(negedge clk);
    req_vc = 8'h30; #1;
    check("body_grant", grant, 4'b0100);
    check("body_gvc", grant_vc, 1);
    check("body_locked", locked, 1);
    check("body_owner", owner, 2);
    @(negedge clk);
    req_tail = 4'b0100; #1;
    check("tail_grant", grant, 4'b0100);
    check("tail_locked", locked, 1);
    check("tail_owner", owner, 2);
    @(negedge clk);
    req = 4'b0011; req_tail = 4'hF; req_vc = 8'h00; #1;
    check("post0_grant", grant, 4'b0001);
    check("post_locked", locked, 0);
    check("post_owner", owner, 0);
    @(negedge clk); #1;
    check("post1_grant", grant, 4'b0010);
    @(negedge clk);

    // credit exhaustion on VC0
    do_reset();
    req = 4'b0001; req_vc = 8'h00; req_tail = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1 check("ex_grant", grant, 4'b0001);
      @(negedge clk);
    end
    credit_in = 4'b0001; #1;
    check("ex_block", grant, 0);
    check("ex_anyg", any_grant, 0);
    check("ex_cav", credit_avail, 4'b1110);
    @(negedge clk);
    credit_in = 4'b0000; #1;
    check("ex_refill", grant, 4'b0001);
    check("ex_cav2", credit_avail, 4'hF);
    @(negedge clk);

    // grant and credit return on VC2 in the same cycle
    do_reset();
    req = 4'b0001; req_vc = 8'h02; req_tail = 4'hF;
    for (int i = 0; i < 2; i++) begin
      #1 check("sim_pre", grant, 4'b0001);
      @(negedge clk);
    end
    credit_in = 4'b0100; #1;
    check("sim_grant", grant, 4'b0001);
    check("sim_gvc", grant_vc, 2);
    @(negedge clk);
    credit_in = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      #1 check("sim_left", grant, 4'b0001);
      @(negedge clk);
    end
    #1;
    check("sim_block", grant, 0);
    check("sim_cerr", credit_err, 0);
    @(negedge clk);

    // credit overflow on VC3 is sticky
    do_reset();
    credit_in = 4'b1000;
    @(negedge clk);
    credit_in = 4'b0000; req = 4'b0001; req_vc = 8'h03; req_tail = 4'hF; #1;
    check("ovf_cerr", credit_err, 1);
    for (int i = 0; i < 4; i++) begin
      #1 check("ovf_grant", grant, 4'b0001);
      @(negedge clk);
    end
    #1;
    check("ovf_block", grant, 0);
    check("ovf_sticky", credit_err, 1);
    @(negedge clk);

    // reset while locked
    do_reset();
    req = 4'b0010; req_vc = 8'h00; req_tail = 4'h0; #1;
    check("rl_cerr", credit_err, 0);
    check("rl_head", grant, 4'b0010);
    @(negedge clk); #1;
    check("rl_locked", locked, 1);
    check("rl_owner", owner, 1);
    reset = 1'b0; req = 4'hF; #1;
    check("rl_force", grant, 0);
    check("rl_forceany", any_grant, 0);
    @(negedge clk); #1;
    check("rl_unlock", locked, 0);
    check("rl_own0", owner, 0);
    check("rl_grant0", grant, 0);
    check("rl_cav", credit_avail, 4'hF);
    reset = 1'b1; req = 4'b0110; req_tail = 4'hF; #1;
    check("rl_first", grant, 4'b0010);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
